bit_field_serializer: RTL

Registered, parametrised successor to the combinational bit selector. It captures an input word with a valid/ready handshake and zero-extends it to a whole number of fields. It then streams those fields one per transfer, from a programmable start index, in either ascending or descending order, with output backpressure. It sits between wide datapath registers and narrow serial consumers: LED/7-segment scanners, UART payload feeders, bit-serial ALUs.

---
 rtl/bit_field_serializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/bit_field_serializer.sv
// Captures a word through a valid/ready handshake, zero-pads it to whole fields, and
// streams the fields from a programmable start index in either order with backpressure.
module bit_field_serializer #(
  parameter int nrOfInputBits  = 8,
  parameter int nrOfOutputBits = 1,
  parameter int nrOfFields     = 8,
  parameter int nrOfselBits    = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [nrOfInputBits-1:0]  dataIn,
  input  logic                      loadValid,
  output logic                      loadReady,
  input  logic                      msbFirst,
  input  logic [nrOfselBits-1:0]    startSel,
  output logic [nrOfOutputBits-1:0] dataOut,
  output logic                      outValid,
  input  logic                      outReady,
  output logic                      outLast,
  output logic [nrOfselBits-1:0]    fieldIndex,
  output logic                      busy
);

  localparam int wordBits = nrOfFields * nrOfOutputBits;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [nrOfselBits-1:0] lastIdx = nrOfselBits'(nrOfFields - 1);
  localparam logic [nrOfselBits-1:0] zeroIdx = nrOfselBits'(0);
  localparam logic [nrOfselBits-1:0] oneIdx  = nrOfselBits'(1);

  logic [0:0]                state_r;
  logic [wordBits-1:0]       word_r;
  logic [nrOfselBits-1:0]    idx_r;
  logic                      dir_r;

  logic                      inShift_s;
  logic                      transfer_s;
  logic                      isLast_s;
  logic                      loadReady_s;
  logic                      loadAccept_s;
  logic [nrOfselBits-1:0]    startIdx_s;
  logic [nrOfOutputBits-1:0] field_s;

  // Handshake decode; loadReady lets a new word slip in on the final transfer.
  always_comb begin
    inShift_s    = (state_r == SHIFT);
    transfer_s   = inShift_s && outReady;
    if (dir_r) begin
      isLast_s = inShift_s && (idx_r == zeroIdx);
    end else begin
      isLast_s = inShift_s && (idx_r == lastIdx);
    end
    loadReady_s  = !reset && !flush && (!inShift_s || (transfer_s && isLast_s));
    loadAccept_s = loadValid && loadReady_s;
  end

  // Out-of-range start indices clamp to the top field.
  always_comb begin
    if (startSel > lastIdx) begin
      startIdx_s = lastIdx;
    end else begin
      startIdx_s = startSel;
    end
  end

  // Field multiplexer over the padded word.
  always_comb begin
    field_s = nrOfOutputBits'(word_r >> (32'(idx_r) * nrOfOutputBits));
  end

  // State, word, direction and index registers; reset beats flush beats load beats transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      word_r  <= {wordBits{1'b0}};
      idx_r   <= zeroIdx;
      dir_r   <= 1'b0;
    end else if (flush) begin
      state_r <= IDLE;
      idx_r   <= zeroIdx;
    end else if (loadAccept_s) begin
      state_r <= SHIFT;
      word_r  <= wordBits'(dataIn);
      dir_r   <= msbFirst;
      idx_r   <= startIdx_s;
    end else if (transfer_s) begin
      if (isLast_s) begin
        state_r <= IDLE;
      end else if (dir_r) begin
        idx_r <= idx_r - oneIdx;
      end else begin
        idx_r <= idx_r + oneIdx;
      end
    end else begin
      state_r <= state_r;
    end
  end

  // dataOut is forced to zero outside SHIFT so a stale word is never visible.
  assign dataOut    = inShift_s ? field_s : {nrOfOutputBits{1'b0}};
  assign outValid   = inShift_s;
  assign busy       = inShift_s;
  assign outLast    = isLast_s;
  assign fieldIndex = idx_r;
  assign loadReady  = loadReady_s;

endmodule
